multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/multicycle_alu.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/add ops, shift-add multiply and restoring
// divide (one bit per cycle), valid/ready handshakes on both sides.
module multicycle_alu #(
    parameter int WIDTH = 19,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             div_by_zero
);
    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // DONE  | result valid, waiting for out_ready
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIV = OP_W'(3);
    localparam logic [OP_W-1:0] OP_INC = OP_W'(4);
    localparam logic [OP_W-1:0] OP_DEC = OP_W'(5);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(6);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(8);
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(9);
    localparam logic [OP_W-1:0] OP_REM = OP_W'(13);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   rem_q;
    logic               is_rem_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               dbz_q;

    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_carry_d;
    logic [WIDTH:0]     sum_ext;
    logic               is_div_op;
    logic [WIDTH-1:0]   mul_acc_d;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_d;
    logic [WIDTH-1:0]   div_quo_d;
    logic               last_step;

    assign is_div_op = (op == OP_DIV) || (op == OP_REM);

    always_comb begin
        alu_res_d   = '0;
        alu_carry_d = 1'b0;
        sum_ext     = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD: begin
                alu_res_d   = sum_ext[WIDTH-1:0];
                alu_carry_d = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res_d   = a - b;
                alu_carry_d = a < b;
            end
            OP_INC: begin
                alu_res_d   = a + WIDTH'(1);
                alu_carry_d = &a;
            end
            OP_DEC: begin
                alu_res_d   = a - WIDTH'(1);
                alu_carry_d = (a == '0);
            end
            OP_AND:  alu_res_d = a & b;
            OP_OR:   alu_res_d = a | b;
            OP_XOR:  alu_res_d = a ^ b;
            OP_NOT:  alu_res_d = ~a;
            default: alu_res_d = '0;
        endcase
    end

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial
    // subtraction and its top bit acts as the borrow.
    assign mul_acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;
    assign div_sh    = {rem_q, opa_q[WIDTH-1]};
    assign div_diff  = div_sh - {1'b0, opb_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_rem_d = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_quo_d = {opa_q[WIDTH-2:0], div_ge};
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            is_rem_q <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        rem_q    <= '0;
                        opa_q    <= a;
                        opb_q    <= b;
                        is_rem_q <= (op == OP_REM);
                        if (op == OP_MUL) begin
                            state_q <= S_MUL;
                        end else if (is_div_op && (b != '0)) begin
                            state_q <= S_DIV;
                        end else begin
                            result_q <= alu_res_d;
                            carry_q  <= alu_carry_d;
                            dbz_q    <= is_div_op;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_d;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        result_q <= mul_acc_d;
                        carry_q  <= 1'b0;
                        dbz_q    <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DIV: begin
                    rem_q <= div_rem_d;
                    opa_q <= div_quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        result_q <= is_rem_q ? div_rem_d : div_quo_d;
                        carry_q  <= 1'b0;
                        dbz_q    <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign negative    = result_q[WIDTH-1];
    assign zero        = (result_q == '0);
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=19): directed vector table,
// random operations against an arithmetic reference, backpressure and reset abort.
module tb_multicycle_alu;
    localparam int     W    = 19;
    localparam longint MASK = (longint'(1) << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [4:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         negative;
    logic         zero;
    logic         carry;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    multicycle_alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .negative   (negative),
        .zero       (zero),
        .carry      (carry),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        longint     a;
        longint     b;
        longint     res;
        bit         c;
        bit         dbz;
        int         lat;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] o, input longint x, input longint y,
                           input longint r, input bit c, input bit d, input int l);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r; v.c = c; v.dbz = d; v.lat = l;
        vt.push_back(v);
    endtask

    task automatic ref_alu(input int o, input longint x, input longint y,
                           output longint r, output bit c, output bit z, output int lat);
        r = 0; c = 0; z = 0; lat = 1;
        case (o)
            0: begin r = (x + y) & MASK; c = (x + y) > MASK; end
            1: begin r = (x - y) & MASK; c = x < y; end
            2: begin r = (x * y) & MASK; lat = W + 1; end
            3: if (y == 0) z = 1; else begin r = x / y; lat = W + 1; end
            4: begin r = (x + 1) & MASK; c = (x == MASK); end
            5: begin r = (x - 1) & MASK; c = (x == 0); end
            6: r = x & y;
            7: r = x | y;
            8: r = x ^ y;
            9: r = (~x) & MASK;
            13: if (y == 0) z = 1; else begin r = x % y; lat = W + 1; end
            default: r = 0;
        endcase
    endtask

    // Drive one request, then measure latency, compare outputs, optionally hold
    // off the consumer for `hold` cycles, and finally hand the result off.
    task automatic run_op(input logic [4:0] o, input longint x, input longint y,
                          input longint er, input bit ec, input bit ed, input int el,
                          input int hold, input string tag);
        int cyc;
        bit busy_ok;
        bit stable;
        logic [W-1:0] r0;
        logic [3:0] f0;
        check({tag, ".in_ready_pre"}, longint'(in_ready), 1);
        in_valid = 1'b1; op = o; a = W'(x); b = W'(y);
        @(posedge clk); #1;
        in_valid = 1'b0; op = 5'($urandom); a = W'($urandom); b = W'($urandom);
        cyc = 1;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, longint'(cyc), longint'(el));
        check({tag, ".busy_in_ready"}, longint'(busy_ok), 1);
        check({tag, ".in_ready_done"}, longint'(in_ready), 0);
        check({tag, ".result"}, longint'(result), er);
        check({tag, ".carry"}, longint'(carry), longint'(ec));
        check({tag, ".div_by_zero"}, longint'(div_by_zero), longint'(ed));
        check({tag, ".negative"}, longint'(negative), (er >> (W - 1)) & 1);
        check({tag, ".zero"}, longint'(zero), longint'(er == 0));
        if (hold > 0) begin
            r0 = result;
            f0 = {negative, zero, carry, div_by_zero};
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (result !== r0 || {negative, zero, carry, div_by_zero} !== f0 ||
                    !out_valid || in_ready) stable = 1'b0;
            end
            check({tag, ".backpressure_stable"}, longint'(stable), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, longint'(out_valid), 0);
        check({tag, ".in_ready_back"}, longint'(in_ready), 1);
    endtask

    initial begin
        longint er;
        bit ec, ed;
        int el;
        logic [4:0] o;
        longint x, y;

        add_vec(5'h00, 'h7FFFF, 1,    0,       1, 0, 1);
        add_vec(5'h01, 3,       5,    'h7FFFE, 1, 0, 1);
        add_vec(5'h09, 0,       0,    'h7FFFF, 0, 0, 1);
        add_vec(5'h02, 1000,    300,  300000,  0, 0, 20);
        add_vec(5'h02, 'h7FFFF, 2,    'h7FFFE, 0, 0, 20);
        add_vec(5'h03, 100,     7,    14,      0, 0, 20);
        add_vec(5'h0D, 100,     7,    2,       0, 0, 20);
        add_vec(5'h03, 5,       0,    0,       0, 1, 1);
        add_vec(5'h0D, 9,       0,    0,       0, 1, 1);
        add_vec(5'h0F, 'h1234,  'h55, 0,       0, 0, 1);
        add_vec(5'h04, 'h7FFFF, 0,    0,       1, 0, 1);
        add_vec(5'h05, 0,       0,    'h7FFFF, 1, 0, 1);
        add_vec(5'h06, 'h0F0F0, 'h3C3C3, 'h0C0C0, 0, 0, 1);
        add_vec(5'h07, 'h0F0F0, 'h3C3C3, 'h3F3F3, 0, 0, 1);
        add_vec(5'h08, 'h0F0F0, 'h3C3C3, 'h33333, 0, 0, 1);
        add_vec(5'h03, 'h7FFFF, 1,    'h7FFFF, 0, 0, 20);
        add_vec(5'h0D, 'h7FFFF, 'h7FFFF, 0,    0, 0, 20);

        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", longint'(in_ready), 1);
        check("reset.out_valid", longint'(out_valid), 0);
        check("reset.result", longint'(result), 0);
        check("reset.zero", longint'(zero), 1);
        check("reset.flags", longint'({negative, carry, div_by_zero}), 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].c, vt[i].dbz,
                   vt[i].lat, (i == 3) ? 5 : 0, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 150; n++) begin
            o = (n % 10 == 9) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 13));
            x = longint'($urandom) & MASK;
            y = (n % 7 == 3) ? 0 : ((n % 3 == 0) ? longint'($urandom_range(1, 50))
                                                 : longint'($urandom) & MASK);
            ref_alu(int'(o), x, y, er, ec, ed, el);
            run_op(o, x, y, er, ec, ed, el, (n % 13 == 5) ? 2 : 0, $sformatf("rnd%0d", n));
        end

        // Abort a divide mid-way with reset, then confirm the block restarts cleanly.
        in_valid = 1'b1; op = 5'h03; a = W'(100); b = W'(7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort.busy", longint'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", longint'(out_valid), 0);
        check("abort.in_ready", longint'(in_ready), 1);
        check("abort.result", longint'(result), 0);
        check("abort.zero", longint'(zero), 1);
        in_valid = 1'b1; op = 5'h00; a = W'(1); b = W'(1);
        @(posedge clk); #1;
        check("abort.no_accept_in_reset", longint'({in_ready, out_valid}), 2);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(5'h00, 2, 3, 5, 0, 0, 1, 0, "post_reset_add");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
